// File: rtl/phase_sequencer.sv
// Programmable-period phase sequencer: a prescaler divides the clock by div+1 and
// steps a PW-bit phase ring up or down, with hold on en and synchronous preload.
module phase_sequencer #(
    parameter int unsigned PW = 2,
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dir,
    input  logic [CW-1:0] div,
    input  logic          load,
    input  logic [PW-1:0] load_phase,
    output logic [CW-1:0] cnt,
    output logic          tick,
    output logic [PW-1:0] phase,
    output logic          wrap
);

    localparam logic [PW-1:0] PHASE_LAST = '1;

    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] phase_nxt;
    logic          at_last;

    // State registers: prescaler count and phase ring
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= '0;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
        end
    end

    // Next-state and combinational strobes; >= lets a lowered div restart at once
    always_comb begin
        cnt_nxt   = cnt;
        phase_nxt = phase;
        tick      = rst & en & ~load & (cnt >= div);
        at_last   = dir ? (phase == '0) : (phase == PHASE_LAST);
        wrap      = tick & at_last;

        if (load) begin
            phase_nxt = load_phase;
            cnt_nxt   = '0;
        end else if (en) begin
            if (tick) begin
                cnt_nxt   = '0;
                phase_nxt = dir ? (phase - PW'(1)) : (phase + PW'(1));
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

endmodule
